// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler
//   Round-robin owner of a shared two-digit seven-segment display. Each
//   requester offers a 14-bit two-digit pattern; the scheduler picks an owner,
//   keeps it for DWELL frames and feeds its pattern to the SEVEN multiplexer.
//   All decisions happen on frame boundaries (every second SEVEN `sig` pulse),
//   so the visible pattern never changes between the two digits of a frame.
//
// Ports
//   clk        : sole clock
//   rst        : synchronous active-high reset (shared with SEVEN)
//   req        : per-requester level request
//   data       : requester i pattern at data[14*i+13 : 14*i]
//   sig        : SEVEN digit-swap pulse, one count per cycle high
//   both7seg   : registered pattern to SEVEN
//   grant      : one-hot owner, zero when idle
//   owner      : index of current or most recent owner
//   busy       : an owner is granted
//   frame_done : one-cycle pulse after each frame boundary
module seg_display_scheduler #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned DWELL        = 8,
    parameter logic [13:0] IDLE_PATTERN = 14'h0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [14*NREQ-1:0]        data,
    input  logic                      sig,
    output logic [13:0]               both7seg,
    output logic [NREQ-1:0]           grant,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int unsigned OW = $clog2(NREQ);
    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t          state;
    logic            phase;
    logic [DW-1:0]   dwell;
    logic [OW-1:0]   last;
    logic            fb;

    logic [13:0]     pat [NREQ];
    logic [OW-1:0]   base;
    logic [OW-1:0]   cand;
    logic [OW-1:0]   sel;
    logic            found;

    // Frame boundary: second digit-swap of the pair.
    assign fb = sig & phase;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            pat[i] = data[14*i +: 14];
        end
    end

    // Round-robin search starting one past the base index. From IDLE the
    // base itself is eligible (offset NREQ); in HOLD the owner is excluded.
    always_comb begin
        base  = (state == IDLE) ? last : owner;
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = OW'((32'(base) + k) % NREQ);
            if (!found && req[cand] && ((k < NREQ) || (state == IDLE))) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= 1'b0;
        end else if (sig) begin
            phase <= ~phase;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dwell      <= '0;
            last       <= OW'(NREQ - 1);
            both7seg   <= IDLE_PATTERN;
            grant      <= '0;
            owner      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= fb;
            if (fb) begin
                case (state)
                    IDLE: begin
                        if (found) begin
                            state    <= HOLD;
                            dwell    <= '0;
                            last     <= sel;
                            owner    <= sel;
                            grant    <= ONE_HOT0 << sel;
                            busy     <= 1'b1;
                            both7seg <= pat[sel];
                        end
                    end
                    HOLD: begin
                        if (!req[owner] || (dwell == DWELL_LAST)) begin
                            if (found) begin
                                dwell    <= '0;
                                last     <= sel;
                                owner    <= sel;
                                grant    <= ONE_HOT0 << sel;
                                both7seg <= pat[sel];
                            end else if (req[owner]) begin
                                // Sole requester re-arms without dropping grant.
                                dwell    <= '0;
                                both7seg <= pat[owner];
                            end else begin
                                state    <= IDLE;
                                dwell    <= '0;
                                grant    <= '0;
                                busy     <= 1'b0;
                                both7seg <= IDLE_PATTERN;
                            end
                        end else begin
                            dwell    <= dwell + 1'b1;
                            both7seg <= pat[owner];
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler. Two instances share all inputs:
// ua uses DWELL=2, ub uses DWELL=1; both have NREQ=4.
module tb_seg_display_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [55:0] data;
    logic        sig;

    logic [13:0] a_seg, b_seg;
    logic [3:0]  a_grant, b_grant;
    logic [1:0]  a_owner, b_owner;
    logic        a_busy, b_busy;
    logic        a_fd, b_fd;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    seg_display_scheduler #(.NREQ(4), .DWELL(2), .IDLE_PATTERN(14'h0000)) ua (
        .clk(clk), .rst(rst), .req(req), .data(data), .sig(sig),
        .both7seg(a_seg), .grant(a_grant), .owner(a_owner),
        .busy(a_busy), .frame_done(a_fd)
    );

    seg_display_scheduler #(.NREQ(4), .DWELL(1), .IDLE_PATTERN(14'h0000)) ub (
        .clk(clk), .rst(rst), .req(req), .data(data), .sig(sig),
        .both7seg(b_seg), .grant(b_grant), .owner(b_owner),
        .busy(b_busy), .frame_done(b_fd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sig_pulse();
        sig = 1'b1;
        tick();
        sig = 1'b0;
    endtask

    // Two sig pulses starting from phase 0; returns just after the FB edge.
    task automatic frame();
        sig_pulse();
        tick();
        sig_pulse();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_a_seg"},   32'(a_seg),   32'h0);
        chk({tag, "_a_grant"}, 32'(a_grant), 32'h0);
        chk({tag, "_a_owner"}, 32'(a_owner), 32'h0);
        chk({tag, "_a_busy"},  32'(a_busy),  32'h0);
        chk({tag, "_a_fd"},    32'(a_fd),    32'h0);
        chk({tag, "_b_grant"}, 32'(b_grant), 32'h0);
        chk({tag, "_b_busy"},  32'(b_busy),  32'h0);
    endtask

    int unsigned exp_a3 [6] = '{0, 0, 1, 1, 0, 0};
    int unsigned exp_b3 [6] = '{0, 1, 0, 1, 0, 1};
    int unsigned exp_b5 [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst  = 1'b1;
        req  = '0;
        data = '0;
        sig  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_reset("reset");

        // Idle frames: frame_done on every second pulse, display blank.
        for (int i = 1; i <= 10; i++) begin
            sig_pulse();
            chk("idle_fd",    32'(a_fd),    (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("idle_grant", 32'(a_grant), 32'h0);
            chk("idle_seg",   32'(a_seg),   32'h0);
            tick();
        end

        // Single requester 2.
        data[28 +: 14] = 14'h1A5B;
        req = 4'b0100;
        sig_pulse();
        chk("req2_p1_grant", 32'(a_grant), 32'h0);
        tick();
        sig_pulse();
        chk("req2_grant", 32'(a_grant), 32'h4);
        chk("req2_owner", 32'(a_owner), 32'h2);
        chk("req2_busy",  32'(a_busy),  32'h1);
        chk("req2_seg",   32'(a_seg),   32'h1A5B);
        chk("req2_fd",    32'(a_fd),    32'h1);
        chk("req2_b_grant", 32'(b_grant), 32'h4);
        for (int f = 0; f < 4; f++) begin
            tick();
            frame();
            chk("hold2_a_grant", 32'(a_grant), 32'h4);
            chk("hold2_a_seg",   32'(a_seg),   32'h1A5B);
            chk("hold2_b_grant", 32'(b_grant), 32'h4);
        end
        req = 4'b0000;
        tick();
        frame();
        chk("release_grant", 32'(a_grant), 32'h0);
        chk("release_busy",  32'(a_busy),  32'h0);
        chk("release_seg",   32'(a_seg),   32'h0);
        chk("release_owner", 32'(a_owner), 32'h2);

        // Two requesters, rotation after the dwell.
        tick();
        do_reset();
        data[0 +: 14]  = 14'h0111;
        data[14 +: 14] = 14'h0222;
        req = 4'b0011;
        for (int f = 0; f < 6; f++) begin
            tick();
            frame();
            chk("rr2_a_owner", 32'(a_owner), exp_a3[f]);
            chk("rr2_a_grant", 32'(a_grant), 32'h1 << exp_a3[f]);
            chk("rr2_a_seg",   32'(a_seg),   (exp_a3[f] == 0) ? 32'h0111 : 32'h0222);
            chk("rr2_b_owner", 32'(b_owner), exp_b3[f]);
        end

        // Owner drops mid-frame while requester 3 waits.
        tick();
        do_reset();
        data[42 +: 14] = 14'h0333;
        req = 4'b0001;
        tick();
        frame();
        chk("drop_fb1", 32'(a_grant), 32'h1);
        req = 4'b1001;
        tick();
        frame();
        chk("drop_fb2", 32'(a_grant), 32'h1);
        req = 4'b1000;
        tick();
        sig_pulse();
        tick();
        chk("drop_mid_grant", 32'(a_grant), 32'h1);
        chk("drop_mid_seg",   32'(a_seg),   32'h0111);
        sig_pulse();
        chk("drop_fb3_grant", 32'(a_grant), 32'h8);
        chk("drop_fb3_seg",   32'(a_seg),   32'h0333);
        req = 4'b1001;
        tick();
        frame();
        chk("drop_fb4_dwell_reset", 32'(a_grant), 32'h8);
        tick();
        frame();
        chk("drop_fb5_rotate", 32'(a_grant), 32'h1);

        // All four requesting from reset.
        tick();
        req = 4'b1111;
        data[0 +: 14]  = 14'h0100;
        data[14 +: 14] = 14'h0101;
        data[28 +: 14] = 14'h0102;
        data[42 +: 14] = 14'h0103;
        do_reset();
        for (int f = 0; f < 5; f++) begin
            tick();
            sig_pulse();
            if (f == 3) begin
                data[14 +: 14] = 14'h2AAA;
                tick();
                chk("live_mid_seg", 32'(a_seg), 32'h0101);
            end else begin
                tick();
            end
            sig_pulse();
            chk("all_b_grant", 32'(b_grant), 32'h1 << exp_b5[f]);
            chk("all_b_seg",   32'(b_seg),   32'h0100 + exp_b5[f]);
            if (f == 2) chk("all_a_fb3_seg", 32'(a_seg), 32'h0101);
            if (f == 3) chk("live_fb4_seg",  32'(a_seg), 32'h2AAA);
        end

        // Reset coinciding with sig while phase=1.
        tick();
        sig_pulse();
        tick();
        rst = 1'b1;
        sig = 1'b1;
        tick();
        rst = 1'b0;
        sig = 1'b0;
        chk_reset("midrst");
        req = 4'b0110;
        sig_pulse();
        chk("post_rst_p1_fd",    32'(a_fd),    32'h0);
        chk("post_rst_p1_grant", 32'(a_grant), 32'h0);
        tick();
        sig_pulse();
        chk("post_rst_grant", 32'(a_grant), 32'h2);
        chk("post_rst_owner", 32'(a_owner), 32'h1);
        chk("post_rst_seg",   32'(a_seg),   32'h2AAA);
        chk("post_rst_fd",    32'(a_fd),    32'h1);
        chk("post_rst_b",     32'(b_grant), 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_display_scheduler.md
# seg_display_scheduler

- Shares one two-digit seven-segment display, driven by the SEVEN digit multiplexer, between NREQ requesters.
- Each requester supplies a 14-bit two-digit pattern. The scheduler grants the display round-robin, holds each owner for a fixed dwell counted in display frames, and drives SEVEN's `both7seg` input.
- It uses SEVEN's `sig` pulse as its scan tick, so ownership and pattern changes land only on frame boundaries and the display never tears.

## Interface

Parameters:
- `NREQ`, 4, number of requesters (2..8).
- `DWELL`, 8, frames an owner holds the display before rotation (>= 1).
- `IDLE_PATTERN`, 14'h0000, pattern shown when no owner.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset; shared with SEVEN.
- `req`  in  NREQ  per-requester request, level.
- `data`  in  14*NREQ  requester i pattern at `data[14*i+13 : 14*i]`, format as SEVEN `both7seg`.
- `sig`  in  1  SEVEN digit-swap pulse; every cycle high counts as one pulse.
- `both7seg`  out  14  registered pattern to SEVEN.
- `grant`  out  NREQ  one-hot owner, or all-zero when idle.
- `owner`  out  clog2(NREQ)  index of current or last owner.
- `busy`  out  1  high while an owner is granted.
- `frame_done`  out  1  one-cycle pulse at each frame boundary.

## Operation

- Internal `phase` bit toggles on each `sig`. A frame boundary (FB) is a cycle with `sig`=1 and `phase`=1, i.e. after both digits have been shown.
- All scheduling decisions, `grant`/`owner`/`busy` updates and `both7seg` loads occur only on the FB edge. Between FBs all outputs hold.

States:
- IDLE:
  - `grant`=0, `busy`=0, `both7seg`=IDLE_PATTERN.
  - At FB, if any `req` is set: select the first set requester searching from `last+1` upward, modulo NREQ.
  - Enter HOLD with `dwell`=0 and `both7seg` = selected requester's `data`.
- HOLD: at each FB, evaluated in this order:
  1. Owner `req`=0, or `dwell`=DWELL-1:
     - Search round-robin from `owner+1`, excluding the owner.
     - If a requester is found, switch to it, reset `dwell`=0 and load its `data`.
     - Otherwise, if the owner's `req`=1, keep the owner, reset `dwell`=0 and reload its `data`.
     - Otherwise go to IDLE and load IDLE_PATTERN.
  2. Otherwise: `dwell`+1, reload the owner's current `data`, so live updates appear once per frame.
- `last` records the most recent owner. Reset value is NREQ-1, so the first grant starts the search at requester 0.
- `dwell` is wide enough to hold DWELL-1 and never wraps; it is compared for equality only.
- With DWELL=1, rotation is evaluated every frame.
- A `req` drop between FBs has no effect until the next FB; the displayed pattern persists meanwhile.
- `data` changes between FBs are ignored.

## Timing

- Reset values, applied at the `rst`=1 edge regardless of `sig`:
  - `both7seg`=IDLE_PATTERN, `grant`=0, `owner`=0, `busy`=0, `frame_done`=0.
  - `phase`=0, `dwell`=0, `last`=NREQ-1, state IDLE.
- `rst` mid-HOLD aborts ownership immediately, with no grace frame.
- `phase` resets together with SEVEN's `digit_select`, so the two stay aligned.
- Outputs change on the FB clock edge and are visible the following cycle. `frame_done`=1 for exactly that one cycle.
- Request-to-grant latency: 1 to 2 `sig` pulses (next FB), plus 1 clock.
- Simultaneous requests: round-robin order only, with no fixed priority.
- Owner re-request in the same FB as its expiry, with no competitors: grant is retained and never glitches low.
- `sig` and `rst` high in the same cycle: reset wins, and `phase` stays 0.

## Test plan

- Reset, then `req`=0 for 10 `sig` pulses: `both7seg`=14'h0000 and `grant`=0 throughout; `frame_done` pulses on every 2nd `sig`.
- `req`=4'b0100 with `data2`=14'h1A5B, asserted before `sig` #1:
  - At the FB on `sig` #2, `grant`=4'b0100, `owner`=2, `busy`=1, `both7seg`=14'h1A5B.
  - With DWELL=8 and no competitors, `grant` stays 4'b0100 indefinitely.
- DWELL=2, `req`=4'b0011 held:
  - Owner sequence per FB is 0,0,1,1,0,0.
  - `both7seg` alternates between `data0` and `data1` every 2 frames.
- Owner 0 drops `req` mid-frame while `req[3]`=1:
  - `grant` holds 4'b0001 until the next FB, then becomes 4'b1000 with `dwell` reset.
- `req`=4'b1111 from reset with DWELL=1:
  - Grants at successive FBs are 0,1,2,3,0.
  - Changing `data1` mid-frame appears only at the following FB.
- `rst` pulsed mid-HOLD with `phase`=1 and `sig`=1 in the same cycle:
  - All outputs return to reset values next cycle.
  - The first subsequent grant goes to the lowest requesting index.
